// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM state encoding and
// the fixed stage indices of the front of the pipeline.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_MEMWAIT = 2'd2,
        ST_REDIR   = 2'd3
    } pc_state_e;

    localparam int S_IF = 0;
    localparam int S_ID = 1;
    localparam int S_EX = 2;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare: a valid load in EX whose destination is read by
// the valid instruction in ID. Writes to x0 never create a dependency.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int RAW = 5
) (
    input  logic [RAW-1:0] ex_rd_i,
    input  logic           ex_rd_vld_i,
    input  logic           ex_is_load_i,
    input  logic           ex_stage_vld_i,
    input  logic           id_stage_vld_i,
    input  logic [RAW-1:0] id_rs1_i,
    input  logic           id_rs1_vld_i,
    input  logic [RAW-1:0] id_rs2_i,
    input  logic           id_rs2_vld_i,
    output logic           hazard_o
);

    logic rs1_match;
    logic rs2_match;
    logic ex_load_live;

    assign rs1_match    = id_rs1_vld_i & (id_rs1_i == ex_rd_i);
    assign rs2_match    = id_rs2_vld_i & (id_rs2_i == ex_rd_i);
    assign ex_load_live = ex_is_load_i & ex_rd_vld_i & (ex_rd_i != '0) & ex_stage_vld_i;

    assign hazard_o = ex_load_live & id_stage_vld_i & (rs1_match | rs2_match);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: arbitrates memory freeze, EX/ID redirects and load-use
// stalls into per-stage stall/flush controls, tracks per-stage valid bits and
// counts stall/flush cycles. Redirect and stall/flush outputs are
// combinational; valid bits, state and counters are registered.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STAGES = 5,
    parameter int XLEN   = 32,
    parameter int RAW    = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_vld,
    input  logic [RAW-1:0]    id_rs1,
    input  logic [RAW-1:0]    id_rs2,
    input  logic              id_rs1_vld,
    input  logic              id_rs2_vld,
    input  logic [RAW-1:0]    ex_rd,
    input  logic              ex_rd_vld,
    input  logic              ex_is_load,
    input  logic              id_jmp_vld,
    input  logic [XLEN-1:0]   id_jmp_addr,
    input  logic              ex_jmp_vld,
    input  logic [XLEN-1:0]   ex_jmp_addr,
    input  logic              mem_busy,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] flush,
    output logic [STAGES-1:0] stage_vld,
    output logic              jmp_vld_IF,
    output logic [XLEN-1:0]   jmp_addr_IF,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic [STAGES-1:0] stage_vld_q, stage_vld_d;
    pc_state_e         state_q, state_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic [STAGES-1:0] stall_c;
    logic [STAGES-1:0] flush_c;
    logic [STAGES-1:0] shift_in;
    logic              jmp_vld_c;
    logic [XLEN-1:0]   jmp_addr_c;
    logic              hazard;
    logic              ex_redir;
    logic              id_redir;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    hazard_detect #(
        .RAW (RAW)
    ) u_hazard_detect (
        .ex_rd_i        (ex_rd),
        .ex_rd_vld_i    (ex_rd_vld),
        .ex_is_load_i   (ex_is_load),
        .ex_stage_vld_i (stage_vld_q[S_EX]),
        .id_stage_vld_i (stage_vld_q[S_ID]),
        .id_rs1_i       (id_rs1),
        .id_rs1_vld_i   (id_rs1_vld),
        .id_rs2_i       (id_rs2),
        .id_rs2_vld_i   (id_rs2_vld),
        .hazard_o       (hazard)
    );

    // Jumps only count when the instruction carrying them is actually valid.
    assign ex_redir = ex_jmp_vld & stage_vld_q[S_EX];
    assign id_redir = id_jmp_vld & stage_vld_q[S_ID];

    // Event arbitration: memory freeze beats EX redirect beats load-use beats ID redirect.
    always_comb begin
        stall_c    = '0;
        flush_c    = '0;
        jmp_vld_c  = 1'b0;
        jmp_addr_c = '0;
        state_d    = ST_RUN;
        if (rst) begin
            flush_c = '1;
        end else if (mem_busy) begin
            stall_c = '1;
            state_d = ST_MEMWAIT;
        end else if (ex_redir) begin
            jmp_vld_c     = 1'b1;
            jmp_addr_c    = ex_jmp_addr;
            flush_c[S_ID] = 1'b1;
            flush_c[S_IF] = 1'b1;
            state_d       = ST_REDIR;
        end else if (hazard) begin
            stall_c[S_ID] = 1'b1;
            stall_c[S_IF] = 1'b1;
            flush_c[S_EX] = 1'b1;
            state_d       = ST_LDSTALL;
        end else if (id_redir) begin
            jmp_vld_c     = 1'b1;
            jmp_addr_c    = id_jmp_addr;
            flush_c[S_IF] = 1'b1;
        end
    end

    // Valid-bit advance: flush inserts a bubble, stall holds, otherwise shift.
    always_comb begin
        shift_in    = {stage_vld_q[STAGES-2:0], if_vld};
        stage_vld_d = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (flush_c[i]) begin
                stage_vld_d[i] = 1'b0;
            end else if (stall_c[i]) begin
                stage_vld_d[i] = stage_vld_q[i];
            end else begin
                stage_vld_d[i] = shift_in[i];
            end
        end
        stall_cnt_d = (|stall_c) ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = (|flush_c) ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_vld_q <= '0;
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stage_vld_q <= stage_vld_d;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall       = stall_c;
    assign flush       = flush_c;
    assign jmp_vld_IF  = jmp_vld_c;
    assign jmp_addr_IF = jmp_addr_c;
    assign stage_vld   = stage_vld_q;
    assign state       = 2'(state_q);
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with literal expectations, then
// randomized traffic, all checked against a behavioural model of the
// pipeline (valid bits as an array, counters as clamped integers).
module tb_pipe_ctrl;

    localparam int STAGES = 5;
    localparam int XLEN   = 32;
    localparam int RAW    = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_vld;
    logic [RAW-1:0]    id_rs1, id_rs2, ex_rd;
    logic              id_rs1_vld, id_rs2_vld, ex_rd_vld, ex_is_load;
    logic              id_jmp_vld, ex_jmp_vld, mem_busy;
    logic [XLEN-1:0]   id_jmp_addr, ex_jmp_addr;

    logic [STAGES-1:0] stall, flush, stage_vld;
    logic              jmp_vld_IF;
    logic [XLEN-1:0]   jmp_addr_IF;
    logic [1:0]        state;
    logic [31:0]       stall_cnt, flush_cnt;

    logic [STAGES-1:0] stall4, flush4, stage_vld4;
    logic              jmp_vld4;
    logic [XLEN-1:0]   jmp_addr4;
    logic [1:0]        state4;
    logic [3:0]        stall_cnt4, flush_cnt4;

    always #5 clk = ~clk;

    pipe_ctrl u_dut (
        .clk(clk), .rst(rst), .if_vld(if_vld),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_vld(id_rs1_vld), .id_rs2_vld(id_rs2_vld),
        .ex_rd(ex_rd), .ex_rd_vld(ex_rd_vld), .ex_is_load(ex_is_load),
        .id_jmp_vld(id_jmp_vld), .id_jmp_addr(id_jmp_addr),
        .ex_jmp_vld(ex_jmp_vld), .ex_jmp_addr(ex_jmp_addr), .mem_busy(mem_busy),
        .stall(stall), .flush(flush), .stage_vld(stage_vld),
        .jmp_vld_IF(jmp_vld_IF), .jmp_addr_IF(jmp_addr_IF), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .if_vld(if_vld),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_vld(id_rs1_vld), .id_rs2_vld(id_rs2_vld),
        .ex_rd(ex_rd), .ex_rd_vld(ex_rd_vld), .ex_is_load(ex_is_load),
        .id_jmp_vld(id_jmp_vld), .id_jmp_addr(id_jmp_addr),
        .ex_jmp_vld(ex_jmp_vld), .ex_jmp_addr(ex_jmp_addr), .mem_busy(mem_busy),
        .stall(stall4), .flush(flush4), .stage_vld(stage_vld4),
        .jmp_vld_IF(jmp_vld4), .jmp_addr_IF(jmp_addr4), .state(state4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model state.
    bit     mv[STAGES];
    int     mstate;
    longint mcs, mcf, mcs4, mcf4;
    // Expected combinational outputs for the current cycle.
    logic [STAGES-1:0] e_stall, e_flush;
    logic              e_jv;
    logic [XLEN-1:0]   e_ja;
    int                e_next_state;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [STAGES-1:0] pack_mv();
        logic [STAGES-1:0] r;
        for (int i = 0; i < STAGES; i++) r[i] = mv[i];
        return r;
    endfunction

    function automatic longint clamp_inc(longint v, longint maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    // Evaluate the model for the inputs now applied and compare every output.
    task automatic settle();
        bit raw_hz, ex_j, id_j;
        #1;
        if (rst) begin
            for (int i = 0; i < STAGES; i++) mv[i] = 0;
            mstate = 0; mcs = 0; mcf = 0; mcs4 = 0; mcf4 = 0;
        end
        raw_hz = ex_is_load && ex_rd_vld && (ex_rd != 0) && mv[2] && mv[1] &&
                 ((id_rs1_vld && id_rs1 == ex_rd) || (id_rs2_vld && id_rs2 == ex_rd));
        ex_j = ex_jmp_vld && mv[2];
        id_j = id_jmp_vld && mv[1];
        e_stall = '0; e_flush = '0; e_jv = 0; e_ja = '0; e_next_state = 0;
        if (rst)           begin e_flush = '1; end
        else if (mem_busy) begin e_stall = '1; e_next_state = 2; end
        else if (ex_j)     begin e_jv = 1; e_ja = ex_jmp_addr; e_flush = 5'b00011; e_next_state = 3; end
        else if (raw_hz)   begin e_stall = 5'b00011; e_flush = 5'b00100; e_next_state = 1; end
        else if (id_j)     begin e_jv = 1; e_ja = id_jmp_addr; e_flush = 5'b00001; end
        chk("stall", 64'(stall), 64'(e_stall));
        chk("flush", 64'(flush), 64'(e_flush));
        chk("jmp_vld_IF", 64'(jmp_vld_IF), 64'(e_jv));
        chk("jmp_addr_IF", 64'(jmp_addr_IF), 64'(e_ja));
        chk("stage_vld", 64'(stage_vld), 64'(pack_mv()));
        chk("state", 64'(state), 64'(mstate));
        chk("stall_cnt", 64'(stall_cnt), 64'(mcs));
        chk("flush_cnt", 64'(flush_cnt), 64'(mcf));
        chk("stall_cnt4", 64'(stall_cnt4), 64'(mcs4));
        chk("flush_cnt4", 64'(flush_cnt4), 64'(mcf4));
    endtask

    // Apply the clock edge to the model, then move to the next falling edge.
    task automatic advance();
        bit nv[STAGES];
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) begin
                if (e_flush[i])      nv[i] = 0;
                else if (e_stall[i]) nv[i] = mv[i];
                else if (i == 0)     nv[i] = if_vld;
                else                 nv[i] = mv[i-1];
            end
            mv = nv;
            mstate = e_next_state;
            if (e_stall != 0) begin mcs = clamp_inc(mcs, 64'hFFFF_FFFF); mcs4 = clamp_inc(mcs4, 15); end
            if (e_flush != 0) begin mcf = clamp_inc(mcf, 64'hFFFF_FFFF); mcf4 = clamp_inc(mcf4, 15); end
        end
        @(negedge clk);
    endtask

    task automatic quiet();
        rst = 0; if_vld = 1;
        id_rs1 = 0; id_rs2 = 0; id_rs1_vld = 0; id_rs2_vld = 0;
        ex_rd = 0; ex_rd_vld = 0; ex_is_load = 0;
        id_jmp_vld = 0; ex_jmp_vld = 0; mem_busy = 0;
        id_jmp_addr = '0; ex_jmp_addr = '0;
    endtask

    task automatic run_quiet(input int n);
        quiet();
        for (int i = 0; i < n; i++) begin settle(); advance(); end
    endtask

    task automatic set_load_use();
        quiet();
        ex_is_load = 1; ex_rd_vld = 1; ex_rd = 5;
        id_rs1 = 5; id_rs1_vld = 1; id_rs2 = 1; id_rs2_vld = 1;
    endtask

    initial begin
        quiet();
        rst = 1;
        @(negedge clk);
        // Reset values.
        settle();
        chk("rst_stall", 64'(stall), 64'h0);
        chk("rst_flush", 64'(flush), 64'h1F);
        chk("rst_stage_vld", 64'(stage_vld), 64'h0);
        chk("rst_state", 64'(state), 64'h0);
        advance();

        // Fill the front of the pipeline.
        run_quiet(3);
        chk("fill_stage_vld", 64'(stage_vld), 64'h07);

        // Load to x0 read as x0: no dependency.
        quiet();
        ex_is_load = 1; ex_rd_vld = 1; ex_rd = 0; id_rs1 = 0; id_rs1_vld = 1;
        settle();
        chk("x0_stall", 64'(stall), 64'h0);
        advance();
        chk("x0_stall_cnt", 64'(stall_cnt), 64'h0);

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID.
        set_load_use();
        settle();
        chk("lu_stall", 64'(stall), 64'h03);
        chk("lu_flush", 64'(flush), 64'h04);
        advance();
        chk("lu_state", 64'(state), 64'h1);
        chk("lu_stall_cnt", 64'(stall_cnt), 64'h1);
        chk("lu_stage_vld", 64'(stage_vld), 64'h1B);
        settle();
        chk("lu_release_stall", 64'(stall), 64'h0);
        advance();
        chk("lu_back_run", 64'(state), 64'h0);

        // EX redirect wins over simultaneous ID redirect.
        run_quiet(3);
        quiet();
        ex_jmp_vld = 1; ex_jmp_addr = 32'h0000_0100;
        id_jmp_vld = 1; id_jmp_addr = 32'h0000_0200;
        settle();
        chk("exj_vld", 64'(jmp_vld_IF), 64'h1);
        chk("exj_addr", 64'(jmp_addr_IF), 64'h100);
        chk("exj_flush", 64'(flush), 64'h03);
        advance();
        chk("exj_vld_low", 64'(stage_vld[1:0]), 64'h0);
        chk("exj_state", 64'(state), 64'h3);
        quiet();
        settle();
        chk("idle_addr", 64'(jmp_addr_IF), 64'h0);
        advance();

        // Memory freeze holds off a pending EX redirect.
        run_quiet(3);
        quiet();
        ex_jmp_vld = 1; ex_jmp_addr = 32'h0000_0040; mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("mb_stall", 64'(stall), 64'h1F);
            chk("mb_no_redir", 64'(jmp_vld_IF), 64'h0);
            advance();
            chk("mb_state", 64'(state), 64'h2);
        end
        mem_busy = 0;
        settle();
        chk("mb_redir", 64'(jmp_vld_IF), 64'h1);
        chk("mb_redir_addr", 64'(jmp_addr_IF), 64'h40);
        advance();

        // Narrow counter saturates.
        quiet();
        mem_busy = 1;
        for (int i = 0; i < 20; i++) begin settle(); advance(); end
        chk("sat_cnt4", 64'(stall_cnt4), 64'hF);

        // Reset during LDSTALL.
        run_quiet(3);
        set_load_use();
        settle();
        advance();
        chk("rl_state", 64'(state), 64'h1);
        rst = 1;
        settle();
        chk("rl_state_rst", 64'(state), 64'h0);
        chk("rl_vld_rst", 64'(stage_vld), 64'h0);
        advance();
        rst = 0;
        settle();
        chk("rl_release_stall", 64'(stall), 64'h0);
        advance();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 99) < 2);
            if_vld      = ($urandom_range(0, 99) < 80);
            id_rs1      = RAW'($urandom_range(0, 3));
            id_rs2      = RAW'($urandom_range(0, 3));
            id_rs1_vld  = $urandom_range(0, 1);
            id_rs2_vld  = $urandom_range(0, 1);
            ex_rd       = RAW'($urandom_range(0, 3));
            ex_rd_vld   = ($urandom_range(0, 99) < 80);
            ex_is_load  = $urandom_range(0, 1);
            id_jmp_vld  = ($urandom_range(0, 99) < 20);
            ex_jmp_vld  = ($urandom_range(0, 99) < 15);
            mem_busy    = ($urandom_range(0, 99) < 15);
            id_jmp_addr = $urandom;
            ex_jmp_addr = $urandom;
            settle();
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
